// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and bus-word helpers for the LCD fill engine.
package lcd_pkg;

    localparam int unsigned H_RES_DEF = 240;
    localparam int unsigned V_RES_DEF = 320;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_CASET = 3'd1;
    localparam logic [ST_W-1:0] ST_CPAR  = 3'd2;
    localparam logic [ST_W-1:0] ST_PASET = 3'd3;
    localparam logic [ST_W-1:0] ST_PPAR  = 3'd4;
    localparam logic [ST_W-1:0] ST_RAMWR = 3'd5;
    localparam logic [ST_W-1:0] ST_PIXEL = 3'd6;

    // One FIFO entry: rs=0 command, rs=1 data.
    typedef struct packed {
        logic        rs;
        logic [15:0] word;
    } lcd_word_t;

    // Command word with the opcode in the low byte.
    function automatic lcd_word_t cmd_word(input logic [7:0] code);
        lcd_word_t w;
        w.rs   = 1'b0;
        w.word = {8'h00, code};
        return w;
    endfunction

    // Address parameter byte: idx 0/1 = start hi/lo, idx 2/3 = end hi/lo.
    function automatic lcd_word_t par_word(input logic [15:0] first,
                                           input logic [15:0] last,
                                           input logic [1:0]  idx);
        lcd_word_t w;
        w.rs = 1'b1;
        case (idx)
            2'd0:    w.word = {8'h00, first[15:8]};
            2'd1:    w.word = {8'h00, first[7:0]};
            2'd2:    w.word = {8'h00, last[15:8]};
            default: w.word = {8'h00, last[7:0]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lcd_fill_engine.sv
// Rectangle fill sequencer: emits CASET/PASET/RAMWR and pixel words into the ILI9341 FIFO.
module lcd_fill_engine
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        wfull,
    output logic        winc,
    output logic [16:0] wdata
);

    logic [ST_W-1:0] state_q, state_d;
    logic [1:0]      pidx_q, pidx_d;
    logic [7:0]      col_q, col_d;
    logic [8:0]      row_q, row_d;
    logic [7:0]      x0_q, x0_d, x1_q, x1_d;
    logic [8:0]      y0_q, y0_d, y1_q, y1_d;
    logic [15:0]     color_q, color_d;
    logic            busy_d, done_d, err_d;
    lcd_word_t       wdata_q, wdata_d;

    logic            req_bad;
    logic            last_col;
    logic            last_pix;

    // A word leaves whenever a fill is active and the FIFO has room.
    assign winc  = (state_q != ST_IDLE) && !wfull;
    assign wdata = wdata_q;

    assign req_bad  = (x0 > x1) || (y0 > y1) ||
                      (32'(x1) >= H_RES) || (32'(y1) >= V_RES);
    assign last_col = (col_q == x1_q);
    assign last_pix = last_col && (row_q == y1_q);

    // Next-state, counter, latch and output-word decode.
    always_comb begin
        state_d = state_q;
        pidx_d  = pidx_q;
        col_d   = col_q;
        row_d   = row_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        color_d = color_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_CASET;
                        pidx_d  = 2'd0;
                        x0_d    = x0;
                        x1_d    = x1;
                        y0_d    = y0;
                        y1_d    = y1;
                        color_d = color;
                    end
                end
            end
            ST_CASET: begin
                if (winc) begin
                    state_d = ST_CPAR;
                    pidx_d  = 2'd0;
                end
            end
            ST_CPAR: begin
                if (winc) begin
                    if (pidx_q == 2'd3) begin
                        state_d = ST_PASET;
                        pidx_d  = 2'd0;
                    end else begin
                        pidx_d = 2'(pidx_q + 2'd1);
                    end
                end
            end
            ST_PASET: begin
                if (winc) begin
                    state_d = ST_PPAR;
                    pidx_d  = 2'd0;
                end
            end
            ST_PPAR: begin
                if (winc) begin
                    if (pidx_q == 2'd3) begin
                        state_d = ST_RAMWR;
                        pidx_d  = 2'd0;
                    end else begin
                        pidx_d = 2'(pidx_q + 2'd1);
                    end
                end
            end
            ST_RAMWR: begin
                if (winc) begin
                    state_d = ST_PIXEL;
                    col_d   = x0_q;
                    row_d   = y0_q;
                end
            end
            ST_PIXEL: begin
                if (winc) begin
                    if (last_pix) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (last_col) begin
                        col_d = x0_q;
                        row_d = 9'(row_q + 9'd1);
                    end else begin
                        col_d = 8'(col_q + 8'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // Word presented next cycle follows the next state, so it holds while stalled.
        case (state_d)
            ST_CASET: wdata_d = cmd_word(CMD_CASET);
            ST_CPAR:  wdata_d = par_word(16'(x0_d), 16'(x1_d), pidx_d);
            ST_PASET: wdata_d = cmd_word(CMD_PASET);
            ST_PPAR:  wdata_d = par_word(16'(y0_d), 16'(y1_d), pidx_d);
            ST_RAMWR: wdata_d = cmd_word(CMD_RAMWR);
            ST_PIXEL: wdata_d = '{rs: 1'b1, word: color_d};
            default:  wdata_d = '0;
        endcase
    end

    // State, counters, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pidx_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pidx_q  <= pidx_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_lcd_fill_engine.sv
// Directed bench for lcd_fill_engine with a word scoreboard fed by a reference model.
module tb_lcd_fill_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  x0, x1;
    logic [8:0]  y0, y1;
    logic [15:0] color;
    logic        busy, done, err;
    logic        wfull;
    logic        winc;
    logic [16:0] wdata;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb_q[$];
    logic [16:0] exp_w;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_wdata = '0;

    lcd_fill_engine dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x0    (x0),
        .x1    (x1),
        .y0    (y0),
        .y1    (y1),
        .color (color),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .wfull (wfull),
        .winc  (winc),
        .wdata (wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_par(input int a, input int b);
        sb_q.push_back({1'b1, 8'h00, 8'((a >> 8) & 255)});
        sb_q.push_back({1'b1, 8'h00, 8'(a & 255)});
        sb_q.push_back({1'b1, 8'h00, 8'((b >> 8) & 255)});
        sb_q.push_back({1'b1, 8'h00, 8'(b & 255)});
    endtask

    // Reference word stream for one valid fill.
    task automatic push_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                             input logic [15:0] c);
        sb_q.push_back(17'h0002A);
        push_par(ax0, ax1);
        sb_q.push_back(17'h0002B);
        push_par(ay0, ay1);
        sb_q.push_back(17'h0002C);
        for (int r = ay0; r <= ay1; r++)
            for (int k = ax0; k <= ax1; k++)
                sb_q.push_back({1'b1, c});
    endtask

    task automatic drive_req(input int ax0, input int ax1, input int ay0, input int ay1,
                             input logic [15:0] c);
        start = 1'b1;
        x0    = 8'(ax0);
        x1    = 8'(ax1);
        y0    = 9'(ay0);
        y1    = 9'(ay1);
        color = c;
    endtask

    task automatic wait_done(input int budget, input bit stall, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            wfull = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            n++;
        end
        wfull = 1'b0;
        check("done_seen", 32'(done), 32'd1);
    endtask

    // Scoreboard and handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (winc === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_word observed=%h expected=none", wdata);
            end else begin
                exp_w = sb_q.pop_front();
                check("wdata", 32'(wdata), 32'(exp_w));
            end
        end
        if (wfull === 1'b1) check("winc_while_full", 32'(winc), 32'd0);
        if (prev_stall) check("wdata_hold", 32'(wdata), 32'(prev_wdata));
        prev_stall = (busy === 1'b1) && (wfull === 1'b1) && (rst === 1'b0);
        prev_wdata = wdata;
    end

    initial begin
        int  n;
        logic saw_done;

        rst   = 1'b1;
        start = 1'b0;
        wfull = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_winc", 32'(winc), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        rst = 1'b0;
        tick();

        // Single pixel with the literal expected stream
        foreach (sb_q[i]) sb_q.delete(i);
        sb_q.push_back(17'h0002A); sb_q.push_back(17'h10000); sb_q.push_back(17'h10005);
        sb_q.push_back(17'h10000); sb_q.push_back(17'h10005); sb_q.push_back(17'h0002B);
        sb_q.push_back(17'h10000); sb_q.push_back(17'h10007); sb_q.push_back(17'h10000);
        sb_q.push_back(17'h10007); sb_q.push_back(17'h0002C); sb_q.push_back(17'h1F800);
        drive_req(5, 5, 7, 7, 16'hF800);
        tick();
        start = 1'b0;
        check("sp_busy", 32'(busy), 32'd1);
        check("sp_first_winc", 32'(winc), 32'd1);
        wait_done(100, 1'b0, n);
        check("sp_latency", 32'(n), 32'd12);
        check("sp_busy_done", 32'(busy), 32'd0);
        check("sp_err", 32'(err), 32'd0);
        check("sp_winc_done", 32'(winc), 32'd0);
        check("sp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Back-to-back start in the done cycle
        drive_req(1, 2, 3, 3, 16'h1234);
        push_fill(1, 2, 3, 3, 16'h1234);
        tick();
        start = 1'b0;
        check("b2b_wdata", 32'(wdata), 32'h0002A);
        check("b2b_winc", 32'(winc), 32'd1);
        wait_done(100, 1'b0, n);
        check("b2b_sb_empty", 32'(sb_q.size()), 32'd0);

        // Random stalls on a 3x2 rectangle
        drive_req(10, 12, 20, 21, 16'h07E0);
        push_fill(10, 12, 20, 21, 16'h07E0);
        tick();
        start = 1'b0;
        wait_done(400, 1'b1, n);
        check("stall_err", 32'(err), 32'd0);
        check("stall_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        // Invalid requests: column out of range, then reversed columns
        drive_req(0, 240, 0, 0, 16'hAAAA);
        tick();
        start = 1'b0;
        check("bad1_err", 32'(err), 32'd1);
        check("bad1_done", 32'(done), 32'd1);
        check("bad1_busy", 32'(busy), 32'd0);
        check("bad1_winc", 32'(winc), 32'd0);
        tick();
        check("bad1_err_clr", 32'(err), 32'd0);
        check("bad1_done_clr", 32'(done), 32'd0);
        drive_req(9, 8, 0, 0, 16'hAAAA);
        tick();
        start = 1'b0;
        check("bad2_err", 32'(err), 32'd1);
        check("bad2_done", 32'(done), 32'd1);
        check("bad2_busy", 32'(busy), 32'd0);
        check("bad2_winc", 32'(winc), 32'd0);
        tick();
        check("bad2_err_clr", 32'(err), 32'd0);
        check("bad2_winc_clr", 32'(winc), 32'd0);

        // 4x4 fill: ignored start while busy, then reset during pixel 3
        drive_req(0, 3, 0, 3, 16'h5555);
        push_fill(0, 3, 0, 3, 16'h5555);
        tick();
        start = 1'b0;
        tick();
        tick();
        drive_req(100, 150, 50, 60, 16'hFFFF);
        tick();
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_err", 32'(err), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_winc", 32'(winc), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_left", 32'(sb_q.size()), 32'd13);
        sb_q.delete();
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        drive_req(30, 31, 40, 41, 16'hABCD);
        push_fill(30, 31, 40, 41, 16'hABCD);
        tick();
        start = 1'b0;
        wait_done(100, 1'b0, n);
        check("post_abort_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        // Full screen, unstalled
        drive_req(0, 239, 0, 319, 16'h001F);
        push_fill(0, 239, 0, 319, 16'h001F);
        tick();
        start = 1'b0;
        n = 0;
        while (winc === 1'b1 && n < 80000) begin
            n++;
            tick();
        end
        check("full_winc_run", 32'(n), 32'd76811);
        check("full_done", 32'(done), 32'd1);
        check("full_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_fill_engine.md
LCD_FILL_ENGINE -- requirements
Module: lcd_fill_engine

Interface
REQ-001 SHALL have parameters: H_RES 240 (column count); V_RES 320 (page/row count).
REQ-002 SHALL have ports:
  - clk  in  1  sole clock, all logic on rising edge
  - rst  in  1  synchronous, active-high reset
  - start  in  1  one-cycle request to fill a rectangle
  - x0  in  8  first column
  - x1  in  8  last column
  - y0  in  9  first row
  - y1  in  9  last row
  - color  in  16  RGB565 pixel value
  - busy  out  1  fill in progress
  - done  out  1  one-cycle completion pulse
  - err  out  1  one-cycle pulse, request rejected
  - wfull  in  1  downstream FIFO full
  - winc  out  1  write strobe to FIFO
  - wdata  out  17  [16]=RS (0 command, 1 data), [15:0]=bus word

Function
REQ-003 SHALL sample start only in IDLE; start while busy=1 SHALL be ignored.
REQ-004 SHALL latch x0, x1, y0, y1 and color on the accepting edge; later input changes SHALL NOT affect the running fill.
REQ-005 SHALL reject a request if x0>x1, y0>y1, x1>=H_RES or y1>=V_RES.
  - Rejection: err=1 and done=1 for exactly one cycle after the accepting edge; zero words written; busy stays 0.
REQ-006 SHALL use states IDLE, CASET, CPAR, PASET, PPAR, RAMWR, PIXEL.
  - IDLE -> CASET on valid start; CASET -> CPAR -> PASET -> PPAR -> RAMWR -> PIXEL -> IDLE.
  - Each transition occurs only on an accepted word.
REQ-007 A word is accepted on a rising edge where winc=1.
  - winc SHALL be 1 exactly when state is not IDLE and wfull=0.
  - winc SHALL be combinational from state and wfull.
REQ-008 While wfull=1, state, counters and wdata SHALL hold.
REQ-009 Word sequence per fill:
  - {0,0x002A}
  - CPAR, 4 words: {1,0x00,x0[15:8]}, {1,0x00,x0[7:0]}, {1,0x00,x1[15:8]}, {1,0x00,x1[7:0]}, with x zero-extended to 16 bits.
  - {0,0x002B}
  - PPAR, 4 words: the same pattern for y0, y1.
  - {0,0x002C}
  - PIXEL: {1,color}, repeated (x1-x0+1)*(y1-y0+1) times.
REQ-010 SHALL count pixels with a 2-bit parameter index, an 8-bit column counter and a 9-bit row counter; no multiplier SHALL be used.
  - Column counter wraps x0..x1; row counter increments on column wrap.
  - Last pixel: column==x1 and row==y1.
REQ-011 Throughput SHALL be one word per cycle when wfull=0; the first winc SHALL be possible in the cycle after the accepting edge.
REQ-012 busy SHALL be 1 from the cycle after acceptance through the cycle the last pixel is accepted.
REQ-013 done SHALL pulse one cycle after the last pixel is accepted, with busy=0 and state IDLE in that cycle.
  - A start in the done cycle SHALL be accepted (back-to-back fills).
REQ-014 err SHALL be 0 for valid fills.

Reset
REQ-015 On rst=1 at a clock edge: state=IDLE, all counters=0, busy=0, done=0, err=0.
  - winc SHALL be 0 in the following cycle; wdata SHALL be 0.
REQ-016 Reset mid-fill SHALL abandon the fill: no further words, and done SHALL NOT pulse for the aborted fill.

Structure
REQ-017 Package lcd_pkg SHALL hold:
  - command codes CMD_CASET=0x2A, CMD_PASET=0x2B, CMD_RAMWR=0x2C
  - H_RES/V_RES defaults
  - the state encoding
REQ-018 Single flat module, no sub-module.
  - Output wdata feeds the existing FIFO that drives the ILI9341 bus interface.

Verification
REQ-019 Single pixel x0=x1=5, y0=y1=7, color=0xF800, wfull=0 -> exactly 12 words: 0x0002A, 0x10000, 0x10005, 0x10000, 0x10005, 0x0002B, 0x10000, 0x10007, 0x10000, 0x10007, 0x0002C, 0x1F800; done one cycle after the last word.
REQ-020 Full screen 0,0,239,319, color=0x001F -> 76811 words total.
  - Parameters: 00, 00, 00, EF and 00, 00, 01, 3F.
  - 76800 words of 0x1001F.
  - winc continuously high for 76811 cycles.
REQ-021 Rectangle 10..12 x 20..21 with random 50% wfull -> same 17-word sequence as with wfull=0; winc never 1 while wfull=1; wdata stable while stalled.
REQ-022 Invalid requests x1=240, then x0=9/x1=8 -> each gives one-cycle err=1 and done=1, zero winc, busy=0.
REQ-023 start pulsed while busy is ignored; rst=1 during pixel 3 of a 4x4 fill -> winc=0 next cycle, busy=0, no done.
  - A new fill afterwards completes normally.
REQ-024 Second start in the done cycle -> first word of the second fill (0x0002A) on the next cycle.
